sonar_scan_scheduler: RTL and testbench

Sequencer for the sonar sweep. It steps the servo through N_POS positions in a back-and-forth pattern and waits for the servo to settle at each one. At each position it requests one distance measurement, then requests one serial transmission of the result. It drives the measure/transmit/zera strobes and the servo position index that the sonar datapath consumes. It also supervises measurements with a timeout so a missing echo cannot stall the sweep.

---
 rtl/sonar_scan_scheduler_if.sv | 30 +++
 rtl/sonar_scan_scheduler.sv | 135 +++++++++++++
 tb/tb_sonar_scan_scheduler.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sonar_scan_scheduler_if.sv
// Handshake bundle between the sonar sweep sequencer and the sonar datapath.
// master = sequencer side, slave = datapath / control side.
interface sonar_scan_scheduler_if #(
    parameter int N_POS = 8
);
    localparam int PW = (N_POS > 1) ? $clog2(N_POS) : 1;

    logic          ligar;
    logic          interromper;
    logic          fim_medida;
    logic          fim_transmissao;
    logic          zera;
    logic          medir;
    logic          transmitir;
    logic [PW-1:0] posicao;
    logic          fim_posicao;
    logic          erro_medida;
    logic          ativo;
    logic [3:0]    db_estado;

    modport master (
        input  ligar, interromper, fim_medida, fim_transmissao,
        output zera, medir, transmitir, posicao, fim_posicao, erro_medida, ativo, db_estado
    );

    modport slave (
        output ligar, interromper, fim_medida, fim_transmissao,
        input  zera, medir, transmitir, posicao, fim_posicao, erro_medida, ativo, db_estado
    );
endinterface

// File: rtl/sonar_scan_scheduler.sv
// Sonar sweep sequencer: back-and-forth servo stepping, settle dwell, one
// measurement plus one serial transmission per position, measurement timeout.
module sonar_scan_scheduler #(
    parameter int N_POS          = 8,
    parameter int T_ASSENTAMENTO = 25000000,
    parameter int T_TIMEOUT      = 2500000
) (
    input  logic                    clock,
    input  logic                    reset,
    sonar_scan_scheduler_if.master  bus
);
    localparam int PW    = (N_POS > 1) ? $clog2(N_POS) : 1;
    localparam int T_MAX = (T_ASSENTAMENTO > T_TIMEOUT) ? T_ASSENTAMENTO : T_TIMEOUT;
    localparam int TW    = $clog2(T_MAX + 1);

    localparam logic [PW-1:0] POS_LAST     = PW'(N_POS - 1);
    localparam logic [TW-1:0] SETTLE_LAST  = TW'(T_ASSENTAMENTO - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(T_TIMEOUT - 1);

    typedef enum logic [3:0] {
        INICIAL        = 4'd0,
        PREPARA        = 4'd1,
        POSICIONA      = 4'd2,
        MEDE           = 4'd3,
        AGUARDA_MEDIDA = 4'd4,
        TRANSMITE      = 4'd5,
        AGUARDA_TX     = 4'd6,
        PROXIMA        = 4'd7
    } state_e;

    // Plain 4-bit register so unused codes 8-F are representable and recoverable.
    logic [3:0]    state_reg;
    logic [PW-1:0] posicao_reg;
    logic          dir_up_reg;
    logic [TW-1:0] timer_reg;
    logic          fim_posicao_reg;
    logic          erro_medida_reg;

    logic [PW-1:0] posicao_next;
    logic          dir_up_next;

    // Triangle-wave stepping: reverse direction at either end position.
    always_comb begin
        posicao_next = posicao_reg;
        dir_up_next  = dir_up_reg;
        if (dir_up_reg) begin
            if (posicao_reg == POS_LAST) begin
                dir_up_next  = 1'b0;
                posicao_next = POS_LAST - 1'b1;
            end else begin
                posicao_next = posicao_reg + 1'b1;
            end
        end else begin
            if (posicao_reg == '0) begin
                dir_up_next  = 1'b1;
                posicao_next = PW'(1);
            end else begin
                posicao_next = posicao_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= INICIAL;
            posicao_reg     <= '0;
            dir_up_reg      <= 1'b1;
            timer_reg       <= '0;
            fim_posicao_reg <= 1'b0;
            erro_medida_reg <= 1'b0;
        end else begin
            fim_posicao_reg <= 1'b0;
            erro_medida_reg <= 1'b0;
            case (state_reg)
                INICIAL: begin
                    if (bus.ligar) state_reg <= PREPARA;
                end
                PREPARA: begin
                    posicao_reg <= '0;
                    dir_up_reg  <= 1'b1;
                    timer_reg   <= '0;
                    state_reg   <= POSICIONA;
                end
                POSICIONA: begin
                    if (timer_reg == SETTLE_LAST) begin
                        timer_reg <= '0;
                        state_reg <= MEDE;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                MEDE: begin
                    timer_reg <= '0;
                    state_reg <= AGUARDA_MEDIDA;
                end
                AGUARDA_MEDIDA: begin
                    // A result arriving on the timeout cycle still counts.
                    if (bus.fim_medida) begin
                        state_reg <= TRANSMITE;
                    end else if (timer_reg == TIMEOUT_LAST) begin
                        erro_medida_reg <= 1'b1;
                        state_reg       <= PROXIMA;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                TRANSMITE: begin
                    state_reg <= AGUARDA_TX;
                end
                AGUARDA_TX: begin
                    if (bus.fim_transmissao) state_reg <= PROXIMA;
                end
                PROXIMA: begin
                    posicao_reg     <= posicao_next;
                    dir_up_reg      <= dir_up_next;
                    fim_posicao_reg <= (posicao_next == '0) || (posicao_next == POS_LAST);
                    timer_reg       <= '0;
                    state_reg       <= bus.interromper ? INICIAL : POSICIONA;
                end
                default: begin
                    state_reg <= INICIAL;
                end
            endcase
        end
    end

    assign bus.zera        = (state_reg == PREPARA);
    assign bus.medir       = (state_reg == MEDE);
    assign bus.transmitir  = (state_reg == TRANSMITE);
    assign bus.ativo       = (state_reg != INICIAL);
    assign bus.posicao     = posicao_reg;
    assign bus.fim_posicao = fim_posicao_reg;
    assign bus.erro_medida = erro_medida_reg;
    assign bus.db_estado   = state_reg;
endmodule

// File: tb/tb_sonar_scan_scheduler.sv
// Directed + randomized bench for sonar_scan_scheduler; expected positions come
// from a triangle-wave model indexed by the number of positions visited.
module tb_sonar_scan_scheduler;
    localparam int N_POS = 4;
    localparam int T_A   = 5;
    localparam int T_TO  = 20;

    logic clock;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   k = 0;
    int   exp_medir = 0;
    int   exp_tx = 0;
    int   seen_medir = 0;
    int   seen_tx = 0;

    sonar_scan_scheduler_if #(.N_POS(N_POS)) bus ();

    sonar_scan_scheduler #(
        .N_POS(N_POS),
        .T_ASSENTAMENTO(T_A),
        .T_TIMEOUT(T_TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    initial begin
        clock = 1'b0;
        forever #10 clock = ~clock;
    end

    always @(negedge clock) begin
        if (bus.medir === 1'b1) seen_medir <= seen_medir + 1;
        if (bus.transmitir === 1'b1) seen_tx <= seen_tx + 1;
    end

    // Position visited at step n of a sweep: 0,1,..,N-1,N-2,..,1,0,1,...
    function automatic int sweep_pos(input int n);
        int period;
        int r;
        period = 2 * (N_POS - 1);
        r = n % period;
        return (r < N_POS) ? r : period - r;
    endfunction

    function automatic int is_end(input int p);
        return (p == 0 || p == N_POS - 1) ? 1 : 0;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_state"}, int'(bus.db_estado), 0);
        chk({tag, "_posicao"}, int'(bus.posicao), 0);
        chk({tag, "_strobes"}, int'({bus.zera, bus.medir, bus.transmitir,
                                      bus.fim_posicao, bus.erro_medida, bus.ativo}), 0);
    endtask

    // Starts in the first settle cycle; returns cycles until medir is seen.
    task automatic wait_medir(input bit stray, output int n);
        n = 0;
        if (stray) begin
            bus.fim_medida = 1'b1;
            bus.fim_transmissao = 1'b1;
            bus.ligar = 1'b1;
            tick();
            n = 1;
            bus.fim_medida = 1'b0;
            bus.fim_transmissao = 1'b0;
            bus.ligar = 1'b0;
            chk("stray_posiciona", int'(bus.db_estado), 2);
        end
        while (bus.medir !== 1'b1 && n < T_A + 5) begin
            tick();
            n++;
        end
        chk("medir_state", int'(bus.db_estado), 3);
    endtask

    // Starts in the medir cycle. dm=0 withholds fim_medida, otherwise it is
    // returned dm cycles after medir; fim_transmissao dt cycles after transmitir.
    task automatic serve(input int dm, input int dt, input bit stop, input bit stray);
        int n;
        bit bad;
        chk("medir_posicao", int'(bus.posicao), sweep_pos(k));
        exp_medir++;
        tick();
        chk("aguarda_state", int'(bus.db_estado), 4);
        if (dm == 0) begin
            bad = 1'b0;
            for (int i = 1; i < T_TO; i++) begin
                if (bus.erro_medida || bus.transmitir) bad = 1'b1;
                tick();
            end
            if (bus.erro_medida || bus.transmitir) bad = 1'b1;
            tick();
            chk("erro_early_or_tx", int'(bad), 0);
            chk("erro_pulse", int'(bus.erro_medida), 1);
            chk("timeout_state", int'(bus.db_estado), 7);
        end else begin
            repeat (dm - 1) tick();
            bus.fim_medida = 1'b1;
            tick();
            bus.fim_medida = 1'b0;
            exp_tx++;
            chk("transmitir", int'(bus.transmitir), 1);
            chk("erro_quiet", int'(bus.erro_medida), 0);
            bus.interromper = stop;
            tick();
            chk("aguarda_tx_state", int'(bus.db_estado), 6);
            if (stray) begin
                bus.fim_medida = 1'b1;
                bus.ligar = 1'b1;
                tick();
                bus.fim_medida = 1'b0;
                bus.ligar = 1'b0;
                chk("stray_aguarda_tx", int'(bus.db_estado), 6);
                repeat (dt - 2) tick();
            end else begin
                repeat (dt - 1) tick();
            end
            bus.fim_transmissao = 1'b1;
            tick();
            bus.fim_transmissao = 1'b0;
            chk("proxima_state", int'(bus.db_estado), 7);
        end
        bus.interromper = stop;
        tick();
        bus.interromper = 1'b0;
        k++;
        chk("posicao_next", int'(bus.posicao), sweep_pos(k));
        chk("fim_posicao", int'(bus.fim_posicao), is_end(sweep_pos(k)));
        chk("after_proxima_state", int'(bus.db_estado), stop ? 0 : 2);
        if (!stop) begin
            wait_medir(stray, n);
            chk("dwell", n, T_A);
        end
    endtask

    initial begin
        int n;
        int dm;
        bus.ligar = 1'b0;
        bus.interromper = 1'b0;
        bus.fim_medida = 1'b0;
        bus.fim_transmissao = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        chk_idle("reset");
        reset = 1'b0;
        tick();

        // Start: zera for one cycle, then exactly T_A settle cycles before medir.
        bus.ligar = 1'b1;
        tick();
        bus.ligar = 1'b0;
        chk("prepara_state", int'(bus.db_estado), 1);
        chk("zera_high", int'(bus.zera), 1);
        chk("ativo_high", int'(bus.ativo), 1);
        chk("no_fim_at_start", int'(bus.fim_posicao), 0);
        tick();
        chk("zera_low", int'(bus.zera), 0);
        chk("posiciona_state", int'(bus.db_estado), 2);
        chk("start_posicao", int'(bus.posicao), 0);
        chk("no_fim_after_start", int'(bus.fim_posicao), 0);
        wait_medir(1'b0, n);
        chk("first_dwell", n, T_A);
        k = 0;

        // Full sweep with fixed latencies.
        for (int i = 0; i < 8; i++) serve(3, 10, 1'b0, 1'b0);

        // Timeout, then fim_medida on exactly the timeout cycle, then strays.
        serve(0, 2, 1'b0, 1'b0);
        serve(T_TO, 4, 1'b0, 1'b0);
        serve(2, 5, 1'b0, 1'b1);

        // Randomized latencies, including occasional withheld results.
        for (int i = 0; i < 12; i++) begin
            dm = int'($urandom_range(0, T_TO));
            serve(dm, int'($urandom_range(2, 12)), 1'b0, 1'b0);
        end
        for (int i = 0; i < 6 && (k % (2 * (N_POS - 1))) != 2; i++)
            serve(int'($urandom_range(1, T_TO)), int'($urandom_range(2, 12)), 1'b0, 1'b0);

        // Interrupt at posicao 2 going up: finishes, lands on 3, goes idle.
        serve(int'($urandom_range(1, T_TO)), int'($urandom_range(2, 12)), 1'b1, 1'b0);
        chk("stop_posicao", int'(bus.posicao), N_POS - 1);
        chk("stop_ativo", int'(bus.ativo), 0);
        tick();
        chk("stop_idle_state", int'(bus.db_estado), 0);

        // Restart from posicao 0.
        bus.ligar = 1'b1;
        tick();
        bus.ligar = 1'b0;
        chk("restart_zera", int'(bus.zera), 1);
        tick();
        chk("restart_posicao", int'(bus.posicao), 0);
        k = 0;
        wait_medir(1'b0, n);
        chk("restart_dwell", n, T_A);
        serve(1, 2, 1'b0, 1'b0);

        // Reset while waiting for the transmission at posicao 1.
        exp_medir++;
        exp_tx++;
        tick();
        bus.fim_medida = 1'b1;
        tick();
        bus.fim_medida = 1'b0;
        chk("rst_tx_transmitir", int'(bus.transmitir), 1);
        repeat (3) tick();
        chk("rst_tx_pre_state", int'(bus.db_estado), 6);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle("rst_in_tx");

        // Reset while settling at posicao 1.
        bus.ligar = 1'b1;
        tick();
        bus.ligar = 1'b0;
        tick();
        wait_medir(1'b0, n);
        exp_medir++;
        exp_tx++;
        tick();
        bus.fim_medida = 1'b1;
        tick();
        bus.fim_medida = 1'b0;
        tick();
        bus.fim_transmissao = 1'b1;
        tick();
        bus.fim_transmissao = 1'b0;
        tick();
        chk("rst_pos_pre_posicao", int'(bus.posicao), 1);
        chk("rst_pos_pre_state", int'(bus.db_estado), 2);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle("rst_in_posiciona");

        // Reset wins over a simultaneous ligar.
        bus.ligar = 1'b1;
        reset = 1'b1;
        tick();
        bus.ligar = 1'b0;
        reset = 1'b0;
        chk_idle("ligar_with_reset");
        tick();
        chk("ligar_with_reset_later", int'(bus.db_estado), 0);

        // Illegal state code recovers to INICIAL even with ligar high.
        force dut.state_reg = 4'hB;
        #1;
        release dut.state_reg;
        chk("illegal_loaded", int'(bus.db_estado), 11);
        bus.ligar = 1'b1;
        tick();
        bus.ligar = 1'b0;
        chk("illegal_recover", int'(bus.db_estado), 0);

        chk("medir_count", seen_medir, exp_medir);
        chk("transmitir_count", seen_tx, exp_tx);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
